// File: rtl/pulpino_mailbox_ctrl_pkg.sv
// Shared constants for the PULPino mailbox controller: status-word bit
// positions and the P2H hold-register state encoding.
package pulpino_mbox_pkg;

    localparam int FLAG_H2P_VALID = 0;
    localparam int FLAG_H2P_FULL  = 1;
    localparam int FLAG_P2H_FULL  = 2;
    localparam int FLAG_OVERFLOW  = 3;
    localparam int FLAG_TIMEOUT   = 4;
    localparam int FLAG_SPUR_ACK  = 5;
    localparam int FLAG_COUNT_LSB = 8;
    localparam int FLAG_COUNT_W   = 4;

    typedef enum logic {
        P2H_IDLE = 1'b0,
        P2H_HOLD = 1'b1
    } p2h_state_e;

endpackage

// File: rtl/pulpino_mailbox_ctrl_if.sv
// Mailbox signal bundle between the host register block / PULPino side
// (master) and the mailbox controller (slave).
interface pulpino_mailbox_ctrl_if #(
    parameter int TIMEOUT_W = 16
);
    logic [31:0]          I_h2p_data;
    logic                 I_h2p_strobe;
    logic [31:0]          O_h2p_data;
    logic                 O_h2p_valid;
    logic                 I_h2p_ready;
    logic [31:0]          I_p2h_data;
    logic                 I_p2h_valid;
    logic                 O_p2h_ready;
    logic [31:0]          O_p2h_data;
    logic                 I_p2h_ack;
    logic [TIMEOUT_W-1:0] I_timeout_cycles;
    logic                 I_clear;
    logic [31:0]          O_flags;

    modport slave (
        input  I_h2p_data, I_h2p_strobe, I_h2p_ready,
        input  I_p2h_data, I_p2h_valid, I_p2h_ack,
        input  I_timeout_cycles, I_clear,
        output O_h2p_data, O_h2p_valid, O_p2h_ready, O_p2h_data, O_flags
    );

    modport master (
        output I_h2p_data, I_h2p_strobe, I_h2p_ready,
        output I_p2h_data, I_p2h_valid, I_p2h_ack,
        output I_timeout_cycles, I_clear,
        input  O_h2p_data, O_h2p_valid, O_p2h_ready, O_p2h_data, O_flags
    );
endinterface

// File: rtl/pulpino_mailbox_ctrl_fifo.sv
// First-word-fall-through FIFO. A push is accepted when there is room or
// when a pop happens in the same cycle; a pop is accepted only when non-empty.
module pulpino_mbox_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_req,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_req,
    output logic             push_ok,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_fire_s;
    logic             push_fire_s;
    logic             full_s;
    logic             empty_s;

    assign full_s      = (count_r == CNT_W'(DEPTH));
    assign empty_s     = (count_r == {CNT_W{1'b0}});
    assign pop_fire_s  = pop_req & ~empty_s;
    assign push_fire_s = push_req & (~full_s | pop_fire_s);

    assign push_ok   = push_fire_s;
    assign head_data = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;

    // Storage array: written at the write pointer on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_fire_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally; occupancy tracks push/pop balance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_fire_s, pop_fire_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pulpino_mailbox_ctrl.sv
// Mailbox controller in the crypto_clk domain: H2P word FIFO, P2H hold
// register with acknowledge/timeout FSM, and a registered status word.
module pulpino_mailbox_ctrl
    import pulpino_mbox_pkg::*;
#(
    parameter int pDEPTH     = 4,
    parameter int pTIMEOUT_W = 16
) (
    input  logic                   crypto_clk,
    input  logic                   reset_n_i,
    pulpino_mailbox_ctrl_if.slave  mbox
);
    localparam int CNT_W = $clog2(pDEPTH) + 1;

    logic [CNT_W-1:0]      h2p_count_s;
    logic                  h2p_full_s;
    logic                  h2p_empty_s;
    logic                  h2p_push_ok_s;
    logic [31:0]           h2p_head_s;

    p2h_state_e            state_r;
    p2h_state_e            state_nx_s;
    logic                  latch_s;
    logic                  p2h_ready_r;
    logic [31:0]           p2h_data_r;

    logic [pTIMEOUT_W-1:0] tmo_cnt_r;
    logic [pTIMEOUT_W-1:0] tmo_cnt_nx_s;
    logic                  tmo_run_s;
    logic                  tmo_hit_s;

    logic                  ovf_r;
    logic                  tmo_r;
    logic                  spur_r;
    logic                  ovf_set_s;
    logic                  spur_set_s;
    logic [FLAG_COUNT_W-1:0] count_ext_s;
    logic [31:0]           flags_nx_s;
    logic [31:0]           flags_r;

    pulpino_mbox_fifo #(
        .DEPTH (pDEPTH),
        .WIDTH (32)
    ) u_h2p_fifo (
        .clk       (crypto_clk),
        .rst_n     (reset_n_i),
        .push_req  (mbox.I_h2p_strobe),
        .push_data (mbox.I_h2p_data),
        .pop_req   (mbox.I_h2p_ready),
        .push_ok   (h2p_push_ok_s),
        .head_data (h2p_head_s),
        .count     (h2p_count_s),
        .full      (h2p_full_s),
        .empty     (h2p_empty_s)
    );

    assign ovf_set_s  = mbox.I_h2p_strobe & ~h2p_push_ok_s;
    assign spur_set_s = mbox.I_p2h_ack & (state_r == P2H_IDLE);
    assign tmo_run_s  = (state_r == P2H_HOLD) & ~mbox.I_p2h_ack &
                        (mbox.I_timeout_cycles != {pTIMEOUT_W{1'b0}});

    // P2H next state: accept a word in IDLE, release it on ack in HOLD.
    always_comb begin
        state_nx_s = state_r;
        latch_s    = 1'b0;
        case (state_r)
            P2H_IDLE: begin
                if (mbox.I_p2h_valid) begin
                    state_nx_s = P2H_HOLD;
                    latch_s    = 1'b1;
                end else begin
                    state_nx_s = P2H_IDLE;
                end
            end
            P2H_HOLD: begin
                if (mbox.I_p2h_ack) begin
                    state_nx_s = P2H_IDLE;
                end else begin
                    state_nx_s = P2H_HOLD;
                end
            end
            default: begin
                state_nx_s = P2H_IDLE;
            end
        endcase
    end

    // Timeout counter: restarts on accept, saturates, flags the step onto the limit.
    always_comb begin
        tmo_cnt_nx_s = tmo_cnt_r;
        tmo_hit_s    = 1'b0;
        if (latch_s) begin
            tmo_cnt_nx_s = {pTIMEOUT_W{1'b0}};
        end else if (tmo_run_s) begin
            if (tmo_cnt_r != {pTIMEOUT_W{1'b1}}) begin
                tmo_cnt_nx_s = tmo_cnt_r + pTIMEOUT_W'(1);
            end else begin
                tmo_cnt_nx_s = tmo_cnt_r;
            end
            tmo_hit_s = (tmo_cnt_nx_s == mbox.I_timeout_cycles) &&
                        (tmo_cnt_nx_s != tmo_cnt_r);
        end else begin
            tmo_cnt_nx_s = tmo_cnt_r;
        end
    end

    // P2H state, ready flag, hold register and timeout counter.
    always_ff @(posedge crypto_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= P2H_IDLE;
            p2h_ready_r <= 1'b1;
            p2h_data_r  <= 32'd0;
            tmo_cnt_r   <= {pTIMEOUT_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            p2h_ready_r <= (state_nx_s == P2H_IDLE);
            tmo_cnt_r   <= tmo_cnt_nx_s;
            if (latch_s) begin
                p2h_data_r <= mbox.I_p2h_data;
            end
        end
    end

    // Sticky error bits: a same-cycle set wins over I_clear.
    always_ff @(posedge crypto_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ovf_r  <= 1'b0;
            tmo_r  <= 1'b0;
            spur_r <= 1'b0;
        end else begin
            ovf_r  <= ovf_set_s  | (ovf_r  & ~mbox.I_clear);
            tmo_r  <= tmo_hit_s  | (tmo_r  & ~mbox.I_clear);
            spur_r <= spur_set_s | (spur_r & ~mbox.I_clear);
        end
    end

    // Assemble the status word from the current internal state.
    always_comb begin
        count_ext_s                = {FLAG_COUNT_W{1'b0}};
        count_ext_s[CNT_W-1:0]     = h2p_count_s;
        flags_nx_s                 = 32'd0;
        flags_nx_s[FLAG_H2P_VALID] = ~h2p_empty_s;
        flags_nx_s[FLAG_H2P_FULL]  = h2p_full_s;
        flags_nx_s[FLAG_P2H_FULL]  = (state_r == P2H_HOLD);
        flags_nx_s[FLAG_OVERFLOW]  = ovf_r;
        flags_nx_s[FLAG_TIMEOUT]   = tmo_r;
        flags_nx_s[FLAG_SPUR_ACK]  = spur_r;
        flags_nx_s[FLAG_COUNT_LSB +: FLAG_COUNT_W] = count_ext_s;
    end

    // Status word register, one cycle behind the internal state.
    always_ff @(posedge crypto_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            flags_r <= 32'd0;
        end else begin
            flags_r <= flags_nx_s;
        end
    end

    assign mbox.O_h2p_data  = h2p_head_s;
    assign mbox.O_h2p_valid = ~h2p_empty_s;
    assign mbox.O_p2h_ready = p2h_ready_r;
    assign mbox.O_p2h_data  = p2h_data_r;
    assign mbox.O_flags     = flags_r;

endmodule
